sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer placed directly downstream of the enabled D flip-flop stage.
- Each rising clk edge with en=1 samples the 1-bit registered stream d into an internal shift register.
- After WIDTH samples, the full word is transferred to a holding register q and a one-cycle valid strobe is raised.
- Gives the downstream parallel logic a stable word while the next word is being collected.

Parameters:
- WIDTH, 8: word length in bits; legal range 2..32.
- MSB_FIRST, 1: 1 means the first received bit lands in q[WIDTH-1]; 0 means the first received bit lands in q[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; d is taken only on edges where en=1.
- clr  input  1  synchronous clear of the word in progress.
- d  input  1  serial data bit.
- q  output  WIDTH  last completed word, held until the next word completes.
- valid  output  1  one-cycle strobe; high in the cycle after the edge that completes a word.
- bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current word (0..WIDTH-1).
- busy  output  1  high while bit_cnt != 0, i.e. a partial word is held.

Behaviour:
- Reset (async, immediate): sr=0, q=0, valid=0, bit_cnt=0, busy=0. Asserting reset mid-word discards the partial word. The first edge after reset release starts a fresh word.
- FSM has two states, derived from bit_cnt:
  - IDLE (bit_cnt=0): an edge with en=1 moves to COLLECT.
  - COLLECT: the edge that takes the WIDTH-th sample returns to IDLE.
  - clr or reset returns to IDLE.
- Shift rule on each edge with en=1 and clr=0:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
- Completion:
  - On the edge where bit_cnt=WIDTH-1, en=1 and clr=0: q <= the shifted value including the current d, valid <= 1, bit_cnt <= 0, sr <= 0.
  - Latency: q and valid update on the same edge as the last sample.
- valid is high for exactly one cycle per completed word and low on every other cycle, including cycles with en=0.
- en=0: sr, bit_cnt and q hold; valid <= 0.
- clr=1: on the next edge sr <= 0 and bit_cnt <= 0; q is untouched; valid <= 0.
- clr=1 together with en=1: clr wins and the sample is discarded, even on the WIDTH-th bit (no valid).
- Back-to-back words with continuous en=1: valid pulses every WIDTH cycles with no gap cycle; bit_cnt wraps from WIDTH-1 to 0.
- q changes only on word completion or reset, never on partial words.
- Between clk edges, d and en may change arbitrarily; only their values at the rising edge matter.

Decomposition:
- Shared header (sipo_defs.vh) holds:
  - default WIDTH;
  - state encodings ST_IDLE=1'b0 and ST_COLLECT=1'b1;
  - the macro for the counter width, $clog2(WIDTH).
- Sub-module dff_r_en: a WIDTH-parameterised register with async active-high reset and enable, in the same flavour as the existing enabled D flip-flop.
  - Instanced once for the q holding register, with en = word-complete.
  - The shift register and counter stay in the top module.

Test Plan:
- Word capture, MSB_FIRST=1, WIDTH=8: after reset, en=1, d=1,0,1,1,0,0,1,0 on 8 consecutive edges. Required: q=8'hB2 and valid=1 for one cycle after the 8th edge, then valid=0 and bit_cnt=0.
- Word capture, LSB first: same bit sequence with MSB_FIRST=0. Required: q=8'h4D.
- Enable gaps: same sequence as the first scenario with en=0 for 3 cycles after bit 4, during which d toggles each cycle. Required: bit_cnt holds at 4 during the gap, busy=1, q stays 8'h00, and the final result is q=8'hB2 with a single valid pulse.
- Clear during a word:
  - Capture 8'hB2 first.
  - Send 5 bits, then clr=1 together with en=1 for one edge. Required: bit_cnt=0, q stays 8'hB2, no valid.
  - Then send bits of 8'h3C. Required: q=8'h3C.
- Back-to-back words: continuous en=1, bits of 8'hA5 then 8'h3C (MSB first). Required: valid pulses exactly 8 cycles apart, q=8'hA5 then 8'h3C, no dropped bit at the wrap.
- Reset mid-word: after 6 bits, pulse reset asynchronously between edges. Required: q=0, bit_cnt=0 and busy=0 immediately, without waiting for a clk edge. A following full word 8'hFF gives q=8'hFF with one valid pulse.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared default word length and FSM state encodings for sipo_deser
package sipo_deser_pkg;
    localparam int SIPO_WIDTH = 8;
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;
endpackage

// File: rtl/sipo_deser_dff_r_en.sv
// dff_r_en: W-bit register with async active-high reset and load enable
//   clk, reset : clock and async reset (clears q)
//   en         : load d into q on the rising edge
//   d, q       : data in / registered data out
module dff_r_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with held output word and valid strobe
//   clk, reset : clock and async active-high reset
//   en, clr    : sample enable; sync clear of the word in progress (clr wins)
//   d          : serial data bit
//   q, valid   : last completed word; one-cycle strobe after completion
//   bit_cnt    : bits collected in the current word
//   busy       : a partial word is held
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             busy
);
    logic [WIDTH-1:0] sr_q, sr_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, done;
    state_t           state;

    // the FSM state is fully implied by the bit counter
    assign state   = (cnt_q == '0) ? ST_IDLE : ST_COLLECT;
    assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};
    assign done    = en && !clr && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            sr_d    = done ? '0 : shifted;
            cnt_d   = done ? '0 : cnt_q + 1'b1;
            valid_d = done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // holding register loads the fully shifted word, including the final bit
    dff_r_en #(.W(WIDTH)) u_hold (
        .clk   (clk),
        .reset (reset),
        .en    (done),
        .d     (shifted),
        .q     (q)
    );

    assign valid   = valid_q;
    assign bit_cnt = cnt_q;
    assign busy    = (state == ST_COLLECT);
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench for MSB-first and LSB-first sipo_deser instances
module tb_sipo_deser;
    logic       clk = 1'b0, reset = 1'b1, en = 1'b0, clr = 1'b0, d = 1'b0;
    logic [7:0] q_m, q_l;
    logic       valid_m, valid_l, busy_m, busy_l;
    logic [2:0] cnt_m, cnt_l;
    logic [7:0] exp_m[$], exp_l[$];
    int         total = 0, passed = 0, cyc = 0, prev_v = 0, last_v = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d),
        .q(q_m), .valid(valid_m), .bit_cnt(cnt_m), .busy(busy_m));

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d),
        .q(q_l), .valid(valid_l), .bit_cnt(cnt_l), .busy(busy_l));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // monitor: every valid strobe must match the oldest expected word
    always @(negedge clk) begin
        if (valid_m) begin
            prev_v = last_v;
            last_v = cyc;
            if (exp_m.size() == 0) chk("unexpected_valid_msb", 32'(q_m), 32'hFFFF_FFFF);
            else chk("word_msb", 32'(q_m), 32'(exp_m.pop_front()));
        end
        if (valid_l) begin
            if (exp_l.size() == 0) chk("unexpected_valid_lsb", 32'(q_l), 32'hFFFF_FFFF);
            else chk("word_lsb", 32'(q_l), 32'(exp_l.pop_front()));
        end
    end

    task automatic step(input logic e, input logic c, input logic b);
        en = e; clr = c; d = b;
        @(posedge clk);
        #1;
    endtask

    // sends bits w[7-lo] .. w[7-hi+1]; queues the word when its final bit goes out
    task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (i == 7) begin
                exp_m.push_back(w);
                exp_l.push_back(rev8(w));
            end
            step(1'b1, 1'b0, w[7-i]);
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
        #1;
        chk({tag, "_q"}, 32'(q_m), 0);
        chk({tag, "_cnt"}, 32'(cnt_m), 0);
        chk({tag, "_busy"}, 32'(busy_m), 0);
        chk({tag, "_q_lsb"}, 32'(q_l), 0);
        #1 reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(q_m), 0);
        chk("reset_valid", 32'(valid_m), 0);
        chk("reset_cnt", 32'(cnt_m), 0);
        chk("reset_busy", 32'(busy_m), 0);
        reset = 1'b0;

        // basic capture: B2 MSB-first, 4D LSB-first
        send_bits(8'hB2, 0, 8);
        chk("cap_valid", 32'(valid_m), 1);
        chk("cap_q_msb", 32'(q_m), 32'hB2);
        chk("cap_q_lsb", 32'(q_l), 32'h4D);
        step(1'b0, 1'b0, 1'b0);
        chk("cap_valid_drop", 32'(valid_m), 0);
        chk("cap_cnt", 32'(cnt_m), 0);

        // enable gap after bit 4 with d toggling
        async_reset("rst1");
        send_bits(8'hB2, 0, 4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0]);
            chk("gap_cnt", 32'(cnt_m), 4);
            chk("gap_busy", 32'(busy_m), 1);
            chk("gap_q", 32'(q_m), 0);
            chk("gap_valid", 32'(valid_m), 0);
        end
        send_bits(8'hB2, 4, 8);
        chk("gap_final_q", 32'(q_m), 32'hB2);

        // clr on the 6th edge, then a fresh word
        send_bits(8'h5A, 0, 5);
        chk("clr_pre_cnt", 32'(cnt_m), 5);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_cnt", 32'(cnt_m), 0);
        chk("clr_busy", 32'(busy_m), 0);
        chk("clr_q", 32'(q_m), 32'hB2);
        chk("clr_valid", 32'(valid_m), 0);
        send_bits(8'h3C, 0, 8);
        chk("clr_after_q", 32'(q_m), 32'h3C);

        // clr on what would be the last bit: no word completes
        send_bits(8'hFF, 0, 7);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_last_valid", 32'(valid_m), 0);
        chk("clr_last_q", 32'(q_m), 32'h3C);

        // back-to-back words with no gap
        send_bits(8'hA5, 0, 8);
        chk("b2b_first_q", 32'(q_m), 32'hA5);
        send_bits(8'h3C, 0, 8);
        chk("b2b_second_q", 32'(q_m), 32'h3C);
        step(1'b0, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(last_v - prev_v), 8);

        // async reset mid-word, then a full word
        send_bits(8'h96, 0, 6);
        chk("mid_cnt", 32'(cnt_m), 6);
        async_reset("rst2");
        send_bits(8'hFF, 0, 8);
        chk("ff_q", 32'(q_m), 32'hFF);
        step(1'b0, 1'b0, 1'b0);
        chk("ff_valid_drop", 32'(valid_m), 0);

        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("sb_drained_msb", 32'(exp_m.size()), 0);
        chk("sb_drained_lsb", 32'(exp_l.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
